sync_fifo_param: RTL and testbench

- Parametrised synchronous FIFO for the write-data path, intended as the general-purpose replacement for fixed-size data stacks.
- Adds the following:
  - depth set as a power of two by parameter;
  - standard or first-word-fall-through (FWFT) read mode;
  - run-time programmable almost-full/almost-empty thresholds;
  - occupancy count output;
  - pass-through write when full;
  - sticky overflow/underflow error flags.
- Single clock domain; sits between a write-data producer and the memory-side consumer.

---
 rtl/sync_fifo_param.sv | 134 +++++++++++++
 tb/tb_sync_fifo_param.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Single-clock FIFO between a write-data producer and the memory-side
//   consumer. Depth is 2**ADDR_W. The read side is either registered
//   (FWFT=0, one cycle of read latency) or first-word-fall-through
//   (FWFT=1, the head word is shown combinationally).
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   wr_en, wr_data      push request and data
//   rd_en               read request (standard) / pop acknowledge (FWFT)
//   rd_data, rd_valid   read data and its qualifier
//   ae_level, af_level  run-time almost-empty / almost-full thresholds
//   clr_err             clears the sticky overflow / underflow flags
//   count               words stored, 0..DEPTH
//   full, almost_full, half_full, almost_empty, empty   status flags
//   overflow, underflow sticky error flags
module sync_fifo_param #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 3,
  parameter int FWFT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic [ADDR_W:0]   ae_level,
  input  logic [ADDR_W:0]   af_level,
  input  logic              clr_err,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              almost_full,
  output logic              half_full,
  output logic              almost_empty,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int            DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] HALF_C  = (ADDR_W+1)'(DEPTH/2);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              rd_acc, wr_acc;

  // Status flags come straight from the count register, so they trail an
  // accepted operation by one cycle.
  always_comb begin
    full         = (count_q == DEPTH_C);
    empty        = (count_q == '0);
    half_full    = (count_q >= HALF_C);
    almost_full  = (count_q >= af_level);
    almost_empty = (count_q <= ae_level);
  end

  // A write into a full FIFO still goes in when a read frees the slot in
  // the same edge; the read always needs a stored word.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    // Setting beats clearing when both happen together.
    ovf_d = (wr_en & full & ~rd_en) | (ovf_q & ~clr_err);
    unf_d = (rd_en & empty)         | (unf_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is not reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wr_ptr_q] <= wr_data;
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [DATA_W-1:0] rd_data_q;
      logic              rd_valid_q;
      // On write-while-full wr_ptr == rd_ptr; the read here sees the old
      // word because the memory update is non-blocking.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          if (rd_acc) rd_data_q <= mem[rd_ptr_q];
          rd_valid_q <= rd_acc;
        end
      end
      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end else begin : g_fwft
      assign rd_valid = ~empty;
      assign rd_data  = empty ? '0 : mem[rd_ptr_q];
    end
  endgenerate

  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;
  localparam int DW = 64;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW:0]   ae_level, af_level;

  // standard-mode DUT
  logic          s_wr_en, s_rd_en, s_clr_err;
  logic [DW-1:0] s_wr_data, s_rd_data;
  logic          s_rd_valid, s_full, s_af, s_hf, s_ae, s_empty, s_ovf, s_unf;
  logic [AW:0]   s_count;

  // FWFT DUT
  logic          f_wr_en, f_rd_en, f_clr_err;
  logic [DW-1:0] f_wr_data, f_rd_data;
  logic          f_rd_valid, f_full, f_af, f_hf, f_ae, f_empty, f_ovf, f_unf;
  logic [AW:0]   f_count;

  sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_data(s_wr_data), .rd_en(s_rd_en),
    .rd_data(s_rd_data), .rd_valid(s_rd_valid), .ae_level(ae_level), .af_level(af_level),
    .clr_err(s_clr_err), .count(s_count), .full(s_full), .almost_full(s_af),
    .half_full(s_hf), .almost_empty(s_ae), .empty(s_empty), .overflow(s_ovf),
    .underflow(s_unf));

  sync_fifo_param #(.DATA_W(DW), .ADDR_W(AW), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .ae_level(ae_level), .af_level(af_level),
    .clr_err(f_clr_err), .count(f_count), .full(f_full), .almost_full(f_af),
    .half_full(f_hf), .almost_empty(f_ae), .empty(f_empty), .overflow(f_ovf),
    .underflow(f_unf));

  int n_chk = 0;
  int n_err = 0;

  // scoreboard: words pushed on accepted writes, popped when rd_valid shows up
  logic [DW-1:0] mq[$];
  bit m_ovf, m_unf;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags();
    int cnt;
    cnt = mq.size();
    chk("count",        64'(s_count), 64'(cnt));
    chk("full",         64'(s_full),  64'(cnt == DEPTH));
    chk("empty",        64'(s_empty), 64'(cnt == 0));
    chk("half_full",    64'(s_hf),    64'(cnt >= DEPTH/2));
    chk("almost_full",  64'(s_af),    64'(cnt >= int'(af_level)));
    chk("almost_empty", 64'(s_ae),    64'(cnt <= int'(ae_level)));
    chk("overflow",     64'(s_ovf),   64'(m_ovf));
    chk("underflow",    64'(s_unf),   64'(m_unf));
  endtask

  task automatic std_step(input bit we, input logic [DW-1:0] wd, input bit re, input bit ce);
    int cnt;
    bit racc, wacc;
    logic [DW-1:0] expd;
    cnt  = mq.size();
    racc = re && (cnt != 0);
    wacc = we && ((cnt != DEPTH) || re);
    m_ovf = (we && cnt == DEPTH && !re) || (m_ovf && !ce);
    m_unf = (re && cnt == 0) || (m_unf && !ce);
    s_wr_en = we; s_wr_data = wd; s_rd_en = re; s_clr_err = ce;
    @(posedge clk); #1;
    s_wr_en = 1'b0; s_rd_en = 1'b0; s_clr_err = 1'b0;
    chk("rd_valid", 64'(s_rd_valid), 64'(racc));
    if (s_rd_valid && racc) begin
      expd = mq.pop_front();
      chk("rd_data", s_rd_data, expd);
    end else if (racc) begin
      void'(mq.pop_front());
    end
    if (wacc) mq.push_back(wd);
    chk_flags();
  endtask

  task automatic rst_cycle(input bit we);
    rst = 1'b1; s_wr_en = we; s_wr_data = 64'hDEAD; f_wr_en = we; f_wr_data = 64'hDEAD;
    @(posedge clk); #1;
    rst = 1'b0; s_wr_en = 1'b0; f_wr_en = 1'b0;
    mq.delete(); m_ovf = 0; m_unf = 0;
    chk("rst_rd_valid", 64'(s_rd_valid), 64'd0);
    chk("rst_rd_data",  s_rd_data, 64'd0);
    chk_flags();
    chk("rst_f_count", 64'(f_count), 64'd0);
    chk("rst_f_valid", 64'(f_rd_valid), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] d;
    rst = 1'b1; ae_level = 4'd2; af_level = 4'd6;
    s_wr_en = 0; s_rd_en = 0; s_clr_err = 0; s_wr_data = '0;
    f_wr_en = 0; f_rd_en = 0; f_clr_err = 0; f_wr_data = '0;
    m_ovf = 0; m_unf = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_cycle(1'b0);

    // fill, then overflow
    for (int i = 0; i < DEPTH; i++) std_step(1, 64'h10 + 64'(i), 0, 0);
    std_step(1, 64'h99, 0, 0);
    // drain, underflow, clear
    for (int i = 0; i < DEPTH; i++) std_step(0, '0, 1, 0);
    std_step(0, '0, 1, 0);
    std_step(0, '0, 0, 1);

    // full + write + read
    for (int i = 0; i < DEPTH; i++) std_step(1, 64'h20 + 64'(i), 0, 0);
    std_step(1, 64'h30, 1, 0);
    for (int i = 0; i < DEPTH; i++) std_step(0, '0, 1, 0);
    // empty + write + read
    std_step(1, 64'h40, 1, 0);
    std_step(0, '0, 1, 1);

    // steady stream at count 3 across pointer wraps
    d = 64'h100;
    for (int i = 0; i < 3; i++) begin std_step(1, d, 0, 0); d++; end
    for (int i = 0; i < 20; i++) begin std_step(1, d, 1, 0); d++; end
    for (int i = 0; i < 3; i++) std_step(0, '0, 1, 0);

    // thresholds changed on the fly: almost_full never, almost_empty only at 0
    af_level = 4'd9; ae_level = 4'd0;
    for (int i = 0; i < DEPTH; i++) std_step(1, 64'h200 + 64'(i), 0, 0);
    af_level = 4'd6; ae_level = 4'd2;
    #1 chk_flags();
    for (int i = 0; i < 3; i++) std_step(0, '0, 1, 0);

    // 5 words stored, reset together with a write
    chk("pre_rst_count", 64'(s_count), 64'd5);
    rst_cycle(1'b1);

    // FWFT: fall-through of a single word
    f_wr_en = 1; f_wr_data = 64'hAA;
    @(posedge clk); #1;
    f_wr_en = 0;
    chk("fwft_valid", 64'(f_rd_valid), 64'd1);
    chk("fwft_data",  f_rd_data, 64'hAA);
    chk("fwft_count", 64'(f_count), 64'd1);
    f_rd_en = 1;
    @(posedge clk); #1;
    f_rd_en = 0;
    chk("fwft_pop_valid", 64'(f_rd_valid), 64'd0);
    chk("fwft_pop_data",  f_rd_data, 64'd0);
    chk("fwft_empty",     64'(f_empty), 64'd1);

    // FWFT: ordered stream of three
    for (int i = 0; i < 3; i++) begin
      f_wr_en = 1; f_wr_data = 64'h50 + 64'(i);
      @(posedge clk); #1;
    end
    f_wr_en = 0;
    for (int i = 0; i < 3; i++) begin
      chk("fwft_seq_data", f_rd_data, 64'h50 + 64'(i));
      f_rd_en = 1;
      @(posedge clk); #1;
    end
    f_rd_en = 0;
    chk("fwft_seq_empty", 64'(f_rd_valid), 64'd0);
    chk("fwft_ovf", 64'(f_ovf), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
